// File: rtl/scan_mux_pkg.sv
// Shared types and default sizing for the scan_mux_reg channel selector.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEF_N_CH    = 12;
    localparam int DEF_SEL_W   = 4;
    localparam int DEF_DWELL   = 50000000;
    localparam int DEF_DWELL_W = 26;

endpackage

// File: rtl/scan_mux_reg_sync2.sv
// Two-flop synchroniser for a bus of quasi-static asynchronous inputs.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel 1-bit selector: manual addressing, round-robin scan
// with per-channel dwell, freeze/hold and out-of-range flagging.
module scan_mux_reg #(
    parameter int N_CH    = scan_mux_pkg::DEF_N_CH,
    parameter int SEL_W   = scan_mux_pkg::DEF_SEL_W,
    parameter int DWELL   = scan_mux_pkg::DEF_DWELL,
    parameter int DWELL_W = scan_mux_pkg::DEF_DWELL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  data_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             freeze,
    output logic             data_out,
    output logic [SEL_W-1:0] ch_out,
    output logic             valid,
    output logic             step
);

    import scan_mux_pkg::*;

    localparam int SYNC_W = N_CH + SEL_W + 2;
    localparam logic [SEL_W:0]     N_CH_W     = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0]   CH_LAST    = SEL_W'(N_CH - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    logic [SYNC_W-1:0]     raw_bus, sync_bus;
    logic [N_CH-1:0]       data_in_s;
    logic [SEL_W-1:0]      sel_s;
    logic                  mode_s, freeze_s;
    logic [2**SEL_W-1:0]   data_pad;
    logic                  sel_in_range;
    logic [SEL_W-1:0]      scan_cur;

    state_t                state_q, state_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]      ch_q, ch_d;
    logic                  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  step_q, step_d;

    assign raw_bus = {freeze, mode, sel, data_in};

    sync2 #(.W(SYNC_W)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_bus),
        .dout (sync_bus)
    );

    assign data_in_s = sync_bus[N_CH-1:0];
    assign sel_s     = sync_bus[N_CH +: SEL_W];
    assign mode_s    = sync_bus[N_CH + SEL_W];
    assign freeze_s  = sync_bus[N_CH + SEL_W + 1];

    // Zero-padded to the full address space so any sel_s indexes safely.
    always_comb begin
        data_pad = '0;
        data_pad[N_CH-1:0] = data_in_s;
    end

    assign sel_in_range = ({1'b0, sel_s} < N_CH_W);
    // A scan resumed from a hold taken in MANUAL on a bad address restarts at 0.
    assign scan_cur = ({1'b0, ch_q} < N_CH_W) ? ch_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        data_d  = data_q;
        valid_d = valid_q;
        step_d  = 1'b0;

        if (freeze_s) begin
            state_d = HOLD;
        end else if (!mode_s) begin
            state_d = MANUAL;
            cnt_d   = '0;
            ch_d    = sel_s;
            valid_d = sel_in_range;
            data_d  = sel_in_range ? data_pad[sel_s] : 1'b0;
        end else if (state_q == MANUAL) begin
            state_d = SCAN;
            cnt_d   = '0;
            ch_d    = sel_in_range ? sel_s : '0;
            valid_d = 1'b1;
            data_d  = data_pad[ch_d];
        end else begin
            // Running scan, or release from HOLD resuming the paused count.
            state_d = SCAN;
            valid_d = 1'b1;
            if (cnt_q == DWELL_LAST) begin
                cnt_d  = '0;
                ch_d   = (scan_cur == CH_LAST) ? '0 : scan_cur + 1'b1;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                ch_d  = scan_cur;
            end
            data_d = data_pad[ch_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MANUAL;
            cnt_q   <= '0;
            ch_q    <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            step_q  <= step_d;
        end
    end

    assign data_out = data_q;
    assign ch_out   = ch_q;
    assign valid    = valid_q;
    assign step     = step_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
// Self-checking bench for scan_mux_reg: vector table plus scoreboarded
// multi-cycle sequences (latency, scan wrap, freeze collision, mode change, reset).
module tb_scan_mux_reg;

    logic        clk;
    logic        rst;
    logic [11:0] data_in;
    logic [3:0]  sel;
    logic        mode;
    logic        freeze;

    logic        data_out, valid, step;
    logic [3:0]  ch_out;
    logic        d1_data, d1_valid, d1_step;
    logic [3:0]  d1_ch;

    scan_mux_reg #(.N_CH(12), .SEL_W(4), .DWELL(4), .DWELL_W(26)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .sel      (sel),
        .mode     (mode),
        .freeze   (freeze),
        .data_out (data_out),
        .ch_out   (ch_out),
        .valid    (valid),
        .step     (step)
    );

    scan_mux_reg #(.N_CH(12), .SEL_W(4), .DWELL(1), .DWELL_W(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .sel      (sel),
        .mode     (mode),
        .freeze   (freeze),
        .data_out (d1_data),
        .ch_out   (d1_ch),
        .valid    (d1_valid),
        .step     (d1_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       d;
        logic [3:0] ch;
        logic       v;
        logic       s;
    } exp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [11:0] din;
        logic        exp_d;
        logic [3:0]  exp_ch;
        logic        exp_v;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string name, input logic d, input logic [3:0] ch,
                        input logic v, input logic s);
        exp_t e;
        e.name = name; e.d = d; e.ch = ch; e.v = v; e.s = s;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued at t=%0t", $time);
        end else begin
            e = sb.pop_front();
            if (data_out !== e.d || ch_out !== e.ch || valid !== e.v || step !== e.s) begin
                failures++;
                $display("FAIL %s: got d=%b ch=%0d v=%b s=%b, want d=%b ch=%0d v=%b s=%b",
                         e.name, data_out, ch_out, valid, step, e.d, e.ch, e.v, e.s);
            end else begin
                $display("ok   %s: d=%b ch=%0d v=%b s=%b", e.name, data_out, ch_out, valid, step);
            end
        end
    endtask

    task automatic check1(input string name, input logic d, input logic [3:0] ch,
                          input logic v, input logic s);
        checks++;
        if (d1_data !== d || d1_ch !== ch || d1_valid !== v || d1_step !== s) begin
            failures++;
            $display("FAIL %s: got d=%b ch=%0d v=%b s=%b, want d=%b ch=%0d v=%b s=%b",
                     name, d1_data, d1_ch, d1_valid, d1_step, d, ch, v, s);
        end else begin
            $display("ok   %s: d=%b ch=%0d v=%b s=%b", name, d1_data, d1_ch, d1_valid, d1_step);
        end
    endtask

    initial begin
        logic [3:0]  seq[4];
        logic [11:0] wrap_din;
        logic [3:0]  c1;

        vecs[0] = '{sel: 4'd13, din: 12'hFFF, exp_d: 1'b0, exp_ch: 4'd13, exp_v: 1'b0};
        vecs[1] = '{sel: 4'd11, din: 12'h800, exp_d: 1'b1, exp_ch: 4'd11, exp_v: 1'b1};
        vecs[2] = '{sel: 4'd0,  din: 12'h001, exp_d: 1'b1, exp_ch: 4'd0,  exp_v: 1'b1};
        vecs[3] = '{sel: 4'd0,  din: 12'hFFE, exp_d: 1'b0, exp_ch: 4'd0,  exp_v: 1'b1};
        vecs[4] = '{sel: 4'd15, din: 12'hFFF, exp_d: 1'b0, exp_ch: 4'd15, exp_v: 1'b0};
        vecs[5] = '{sel: 4'd12, din: 12'hFFF, exp_d: 1'b0, exp_ch: 4'd12, exp_v: 1'b0};
        vecs[6] = '{sel: 4'd7,  din: 12'h080, exp_d: 1'b1, exp_ch: 4'd7,  exp_v: 1'b1};
        vecs[7] = '{sel: 4'd3,  din: 12'hF77, exp_d: 1'b0, exp_ch: 4'd3,  exp_v: 1'b1};
        seq[0] = 4'd10; seq[1] = 4'd11; seq[2] = 4'd0; seq[3] = 4'd1;
        wrap_din = 12'h401;

        // Reset held for two edges, then exact 3-cycle pin-to-output latency.
        rst = 1'b1; mode = 1'b0; sel = 4'd5; data_in = 12'h020; freeze = 1'b0;
        tick(2);
        push("reset_state", 1'b0, 4'd0, 1'b0, 1'b0);
        check_pop();
        rst = 1'b0;
        push("latency_c1", 1'b0, 4'd0, 1'b1, 1'b0);
        push("latency_c2", 1'b0, 4'd0, 1'b1, 1'b0);
        push("latency_c3", 1'b1, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_pop();
        end

        // Manual-mode vector table, including out-of-range addresses.
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel; data_in = vecs[i].din;
            push($sformatf("manual_vec%0d", i), vecs[i].exp_d, vecs[i].exp_ch, vecs[i].exp_v, 1'b0);
            tick(3);
            check_pop();
        end

        // Scan with wrap-around from ch 10; DWELL=1 instance checked alongside.
        mode = 1'b1; sel = 4'd10; data_in = wrap_din;
        for (int k = 0; k < 14; k++)
            push($sformatf("scan_k%0d", k), wrap_din[seq[k/4]], seq[k/4], 1'b1,
                 (k % 4 == 0 && k != 0) ? 1'b1 : 1'b0);
        tick(2);
        for (int k = 0; k < 14; k++) begin
            tick(1);
            check_pop();
            if (k < 4) begin
                c1 = 4'((10 + k) % 12);
                check1($sformatf("dwell1_k%0d", k), wrap_din[c1], c1, 1'b1,
                       (k == 0) ? 1'b0 : 1'b1);
            end
        end

        // Freeze lands in the cycle the counter hits DWELL-1.
        freeze = 1'b1; data_in = 12'hBFE;
        push("frz_pre1", 1'b0, 4'd1, 1'b1, 1'b0);
        push("frz_pre2", 1'b0, 4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            push($sformatf("hold_c%0d", i), 1'b0, 4'd1, 1'b1, 1'b0);
        push("resume_step", 1'b1, 4'd2, 1'b1, 1'b1);
        push("resume_next", 1'b1, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            check_pop();
            if (i == 2) data_in = 12'h002;
            if (i == 3) data_in = 12'h004;
            if (i == 4) freeze = 1'b0;
        end

        // Run on to ch 7, then drop to MANUAL on ch 2 and re-enter SCAN.
        push("scan_ch7", 1'b0, 4'd7, 1'b1, 1'b1);
        tick(19);
        check_pop();
        push("scan_ch7_dwell", 1'b0, 4'd7, 1'b1, 1'b0);
        tick(1);
        check_pop();
        mode = 1'b0; sel = 4'd2;
        push("mchg_c1", 1'b0, 4'd7, 1'b1, 1'b0);
        push("mchg_c2", 1'b0, 4'd7, 1'b1, 1'b0);
        push("mchg_c3", 1'b1, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_pop();
        end
        mode = 1'b1;
        for (int i = 0; i < 6; i++)
            push($sformatf("reenter_c%0d", i), 1'b1, 4'd2, 1'b1, 1'b0);
        push("reenter_step", 1'b0, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check_pop();
        end

        // Reset while frozen, then clean restart in MANUAL.
        freeze = 1'b1;
        push("prehold_c1", 1'b0, 4'd3, 1'b1, 1'b0);
        push("prehold_c2", 1'b0, 4'd3, 1'b1, 1'b0);
        push("prehold_c3", 1'b0, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_pop();
        end
        rst = 1'b1;
        push("rst_in_hold", 1'b0, 4'd0, 1'b0, 1'b0);
        tick(1);
        check_pop();
        rst = 1'b0; freeze = 1'b0; mode = 1'b0; sel = 4'd3; data_in = 12'h008;
        push("rst_fresh_c1", 1'b0, 4'd0, 1'b1, 1'b0);
        push("rst_fresh_c2", 1'b0, 4'd0, 1'b1, 1'b0);
        push("rst_fresh_c3", 1'b1, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_pop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_mux_reg.md
Name: scan_mux_reg

Overview:
- Parametrised, registered N-channel 1-bit selector for the board switch/LED flow.
- Operates in two modes:
  - MANUAL: an address input picks one channel.
  - SCAN: channels are stepped round-robin automatically, with a programmable dwell time per channel.
- Adds input synchronisation, a freeze/hold function and range checking, so out-of-range addresses are flagged rather than silently producing 0.
- Sits between the raw switch inputs and the LED outputs.

Parameters:
- N_CH, 12, number of data channels (2..2**SEL_W).
- SEL_W, 4, width of the channel address.
- DWELL, 50000000, clock cycles spent on each channel in SCAN mode (>=1).
- DWELL_W, 26, counter width; must satisfy 2**DWELL_W > DWELL-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  N_CH  asynchronous channel data (switches).
- sel  in  SEL_W  asynchronous manual channel address.
- mode  in  1  asynchronous; 0 = MANUAL, 1 = SCAN.
- freeze  in  1  asynchronous; 1 = hold the current output.
- data_out  out  1  selected channel value (registered).
- ch_out  out  SEL_W  currently selected channel index (registered).
- valid  out  1  1 when ch_out < N_CH.
- step  out  1  one-cycle pulse when SCAN advances to the next channel.

Behaviour:
- Reset: rst sampled high on a rising clk edge sets:
  - data_out=0, ch_out=0, valid=0, step=0;
  - state=MANUAL, dwell counter=0;
  - all synchroniser flops = 0.
- Reset applied mid-scan or mid-freeze aborts immediately; no stale value survives.
- Synchronisation: data_in, sel, mode and freeze each pass through a 2-flop synchroniser.
  - All logic uses the synchronised copies (_s).
  - Pin-to-output latency = 3 clk cycles: 2 sync stages + 1 output register.
- States: MANUAL, SCAN, HOLD. Priority: rst > freeze_s > mode_s.
- MANUAL:
  - Each cycle: ch_out<=sel_s; valid<=(sel_s<N_CH); data_out<=valid ? data_in_s[sel_s] : 0.
  - freeze_s=1 -> HOLD.
  - mode_s=1 -> SCAN:
    - starting channel = sel_s if sel_s<N_CH, else 0;
    - dwell counter cleared.
- SCAN:
  - Dwell counter increments every cycle.
  - When counter==DWELL-1:
    - counter<=0;
    - ch_out<=(ch_out==N_CH-1) ? 0 : ch_out+1 (wrap-around);
    - step=1 for exactly that cycle.
  - data_out tracks data_in_s[ch_out] every cycle, so switch changes within the dwell are visible.
  - valid=1 throughout.
  - With DWELL=1 the channel advances every cycle and step stays high continuously.
  - mode_s=0 -> MANUAL (counter cleared).
  - freeze_s=1 -> HOLD.
- HOLD:
  - data_out, ch_out and valid are held; the counter is paused (not cleared); step=0.
  - data_in changes are ignored.
  - On freeze_s=0: go to the state selected by mode_s at that time.
    - Returning to SCAN resumes from the paused counter value.
    - Going to MANUAL takes sel_s on the next cycle.
- Simultaneous events:
  - freeze_s rising in the same cycle as a dwell expiry: freeze wins; no step and no advance; the counter holds at DWELL-1.
  - The advance then happens on the first SCAN cycle after release.
- Out-of-range manual address (N_CH <= sel_s < 2**SEL_W): data_out=0, valid=0, ch_out=sel_s.
- Widths: compare ch_out and sel_s as unsigned SEL_W bits; no truncation of the counter.

Decomposition:
- Shared package scan_mux_pkg holds:
  - state enum type (MANUAL=2'd0, SCAN=2'd1, HOLD=2'd2);
  - default N_CH/SEL_W/DWELL constants.
- One sub-module, sync2, parametrised by width: 2-flop synchroniser with synchronous reset.
  - Instantiated once over the concatenation {freeze, mode, sel, data_in}.
- Selection, FSM and dwell counter stay in the top module.

Test Plan:
- Reset/latency: N_CH=12, DWELL=4, rst held 2 cycles then released with mode=0, sel=5, data_in=12'h020.
  - Required: all outputs 0 during reset.
  - Required: data_out=1, ch_out=5, valid=1 exactly 3 cycles after release.
- Out-of-range: mode=0, sel=13, data_in=12'hFFF -> data_out=0, valid=0, ch_out=13.
- Scan wrap: mode=1, sel=10, data_in=12'h401, DWELL=4.
  - ch_out sequence: 10,11,0,1, each held 4 cycles.
  - step pulses once per change.
  - data_out sequence: 1,0,1,0.
- Freeze collision: during SCAN, freeze rises so freeze_s goes to 1 in the cycle the counter reaches 3.
  - Required: no step, ch_out unchanged, data_out held while data_in toggles.
  - After freeze drops: advance plus step on the first SCAN cycle.
- Mode change: SCAN on ch 7, mode->0 with sel=2 -> ch_out=2 three cycles after the pin change; counter cleared.
  - Re-entering SCAN then dwells a full DWELL on ch 2.
- Reset mid-HOLD: rst asserted while frozen -> next edge gives outputs 0 and state MANUAL.
